bank_write_sequencer: RTL and testbench

- Sequences writes into the bank distributor feeding the three colour bank RAMs.
- Collects one 128-bit batch per HDMI colour channel, aligns the channels, and issues a single write. Each write carries a global batch address and a one-cycle write strobe; the strobe drives the distributor's clock input.
- Tracks frame position, wraps the address at the end of a frame, flips a ping-pong page select, and flags channel overrun.

---
 rtl/bank_pkg.sv | 21 ++
 rtl/bank_write_sequencer_if.sv | 31 +++
 rtl/batch_hold_slot.sv | 30 +++
 rtl/bank_write_sequencer.sv | 104 ++++++++++
 tb/tb_bank_write_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bank_pkg.sv
// Shared sizing, batch type and sequencer state encoding for the colour bank write path.
// The bank distributor imports this package too, so defaults stay consistent across both blocks.
package bank_pkg;

  localparam int CHANNEL_NUMBER    = 3;
  localparam int CHANNEL_BANDWIDTH = 128;
  localparam int BANK_DEPTH        = 480;

  localparam int ADDR_BITS      = $clog2(BANK_DEPTH * CHANNEL_NUMBER);
  localparam int BANK_ADDR_BITS = $clog2(BANK_DEPTH);
  localparam int DEPTH_OFFSET   = BANK_DEPTH / CHANNEL_NUMBER;

  typedef logic [CHANNEL_BANDWIDTH-1:0] batch_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    WAIT_SOF
  } seq_state_e;

endpackage

// File: rtl/bank_write_sequencer_if.sv
// Batch collection inputs and aligned distributor write outputs of the bank write sequencer.
// The master side is the HDMI batch source; the slave side is the sequencer itself.
interface bank_write_sequencer_if
  import bank_pkg::*;
#(
  parameter int ADDR_W = ADDR_BITS
) ();

  logic                              I_sof;
  logic   [0:CHANNEL_NUMBER-1]       I_batch_valid;
  batch_t [0:CHANNEL_NUMBER-1]       I_batch_data;

  batch_t [0:CHANNEL_NUMBER-1]       O_data_out;
  logic   [ADDR_W-1:0]               O_address_out;
  logic                              O_wr_stb;
  logic                              O_page;
  logic                              O_frame_done;
  logic                              O_overflow;
  logic                              O_busy;

  modport master (
    output I_sof, I_batch_valid, I_batch_data,
    input  O_data_out, O_address_out, O_wr_stb, O_page, O_frame_done, O_overflow, O_busy
  );

  modport slave (
    input  I_sof, I_batch_valid, I_batch_data,
    output O_data_out, O_address_out, O_wr_stb, O_page, O_frame_done, O_overflow, O_busy
  );

endinterface

// File: rtl/batch_hold_slot.sv
// One channel's batch hold with full flag; load beats clear so a batch arriving on a write edge survives.
// Overrun marks a load into an occupied hold that is not being cleared; that batch is dropped.
module batch_hold_slot
  import bank_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  batch_t data,
  output logic   full,
  output batch_t data_q,
  output logic   overrun
);

  assign overrun = load && full && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= 1'b0;
      data_q <= '0;
    end else if (load && (!full || clear)) begin
      full   <= 1'b1;
      data_q <= data;
    end else if (clear) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bank_write_sequencer.sv
// Aligns one batch per colour channel into a single addressed write; strobe one edge after the completing valid.
// No backpressure: a second batch into a waiting channel is dropped and raises sticky O_overflow.
module bank_write_sequencer
  import bank_pkg::*;
#(
  parameter int BANK_DEPTH = bank_pkg::BANK_DEPTH
) (
  input logic                   I_clk,
  input logic                   I_rst,
  bank_write_sequencer_if.slave bus
);

  localparam int CNT_BITS = $clog2(BANK_DEPTH * CHANNEL_NUMBER);
  localparam logic [CNT_BITS-1:0] LAST_ADDR = CNT_BITS'(BANK_DEPTH - 1);

  seq_state_e                  state;
  logic [CNT_BITS-1:0]         addr_cnt;
  logic [CNT_BITS-1:0]         address_out;
  logic                        wr_stb, page, frame_done, overflow, busy;
  logic                        in_run, write_fire, hold_clear;
  logic [0:CHANNEL_NUMBER-1]   hold_full, hold_load, hold_overrun, have_batch;
  batch_t [0:CHANNEL_NUMBER-1] hold_q, wr_data, data_out;

  assign in_run     = (state == RUN);
  assign have_batch = hold_full | bus.I_batch_valid;
  assign write_fire = in_run && !bus.I_sof && (&have_batch);
  assign hold_clear = bus.I_sof || write_fire;

  for (genvar ch = 0; ch < CHANNEL_NUMBER; ch++) begin : g_slot
    // A batch that bypasses an empty hold straight into the write must not also stay held.
    assign hold_load[ch] = bus.I_batch_valid[ch] &&
                           (bus.I_sof || (in_run && !(write_fire && !hold_full[ch])));
    assign wr_data[ch]   = hold_full[ch] ? hold_q[ch] : bus.I_batch_data[ch];

    batch_hold_slot u_slot (
      .clk     (I_clk),
      .rst     (I_rst),
      .load    (hold_load[ch]),
      .clear   (hold_clear),
      .data    (bus.I_batch_data[ch]),
      .full    (hold_full[ch]),
      .data_q  (hold_q[ch]),
      .overrun (hold_overrun[ch])
    );
  end

  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state       <= IDLE;
      addr_cnt    <= '0;
      address_out <= '0;
      data_out    <= '0;
      wr_stb      <= 1'b0;
      page        <= 1'b0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      wr_stb     <= 1'b0;
      // Frame end is reported the cycle after the final strobe, with the page flip.
      frame_done <= wr_stb && (address_out == LAST_ADDR);
      if (wr_stb && (address_out == LAST_ADDR)) begin
        page <= ~page;
      end

      if (bus.I_sof) begin
        state    <= RUN;
        addr_cnt <= '0;
        overflow <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          RUN: begin
            if (write_fire) begin
              data_out    <= wr_data;
              address_out <= addr_cnt;
              wr_stb      <= 1'b1;
              if (addr_cnt == LAST_ADDR) begin
                addr_cnt <= '0;
                state    <= WAIT_SOF;
                busy     <= 1'b0;
              end else begin
                addr_cnt <= addr_cnt + CNT_BITS'(1);
              end
            end
            if (|hold_overrun) begin
              overflow <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.O_data_out    = data_out;
  assign bus.O_address_out = address_out;
  assign bus.O_wr_stb      = wr_stb;
  assign bus.O_page        = page;
  assign bus.O_frame_done  = frame_done;
  assign bus.O_overflow    = overflow;
  assign bus.O_busy        = busy;

endmodule

// File: tb/tb_bank_write_sequencer.sv
// Directed and random batch traffic into a six-deep sequencer, compared each cycle against a frame-level reference.
module tb_bank_write_sequencer;
  import bank_pkg::*;

  localparam int DEPTH = 6;
  localparam int AW    = $clog2(DEPTH * CHANNEL_NUMBER);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   evals = 0;
  int   fails = 0;
  int   obs_stb = 0;
  int   obs_fd = 0;

  bank_write_sequencer_if #(.ADDR_W(AW)) bus ();
  bank_write_sequencer #(.BANK_DEPTH(DEPTH)) dut (.I_clk(clk), .I_rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Reference: mode 0 idle, 1 collecting, 2 frame finished; pending batches per channel.
  int     m_mode, m_cnt, m_addr;
  bit     m_full [3];
  batch_t m_hold [3];
  batch_t m_data [3];
  bit     m_stb, m_fd, m_page, m_ovf, m_busy;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_addr = 0;
    m_stb = 0; m_fd = 0; m_page = 0; m_ovf = 0; m_busy = 0;
    for (int ch = 0; ch < 3; ch++) begin
      m_full[ch] = 0; m_hold[ch] = '0; m_data[ch] = '0;
    end
  endtask

  task automatic model_step();
    bit last_write;
    bit fire;
    last_write = m_stb && (m_addr == DEPTH - 1);
    m_stb = 0;
    m_fd  = last_write;
    if (last_write) m_page = !m_page;
    if (bus.I_sof) begin
      m_mode = 1; m_cnt = 0; m_ovf = 0;
      for (int ch = 0; ch < 3; ch++) begin
        m_full[ch] = bus.I_batch_valid[ch];
        if (m_full[ch]) m_hold[ch] = bus.I_batch_data[ch];
      end
    end else if (m_mode == 1) begin
      fire = 1;
      for (int ch = 0; ch < 3; ch++)
        if (!m_full[ch] && !bus.I_batch_valid[ch]) fire = 0;
      for (int ch = 0; ch < 3; ch++) begin
        if (fire) begin
          m_data[ch] = m_full[ch] ? m_hold[ch] : bus.I_batch_data[ch];
          m_full[ch] = m_full[ch] && bus.I_batch_valid[ch];
          if (m_full[ch]) m_hold[ch] = bus.I_batch_data[ch];
        end else if (bus.I_batch_valid[ch]) begin
          if (m_full[ch]) m_ovf = 1;
          else begin
            m_full[ch] = 1;
            m_hold[ch] = bus.I_batch_data[ch];
          end
        end
      end
      if (fire) begin
        m_stb  = 1;
        m_addr = m_cnt;
        if (m_cnt == DEPTH - 1) begin
          m_cnt  = 0;
          m_mode = 2;
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    m_busy = (m_mode == 1);
  endtask

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    evals++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check($sformatf("%s.stb", tag),   128'(bus.O_wr_stb),      128'(m_stb));
    check($sformatf("%s.fd", tag),    128'(bus.O_frame_done),  128'(m_fd));
    check($sformatf("%s.page", tag),  128'(bus.O_page),        128'(m_page));
    check($sformatf("%s.ovf", tag),   128'(bus.O_overflow),    128'(m_ovf));
    check($sformatf("%s.busy", tag),  128'(bus.O_busy),        128'(m_busy));
    check($sformatf("%s.addr", tag),  128'(bus.O_address_out), 128'(m_addr));
    for (int ch = 0; ch < 3; ch++)
      check($sformatf("%s.data%0d", tag, ch), bus.O_data_out[ch], m_data[ch]);
  endtask

  task automatic drive(bit sof, logic [0:2] vld, batch_t d0, batch_t d1, batch_t d2);
    bus.I_sof            = sof;
    bus.I_batch_valid    = vld;
    bus.I_batch_data[0]  = d0;
    bus.I_batch_data[1]  = d1;
    bus.I_batch_data[2]  = d2;
  endtask

  task automatic tick(string tag);
    model_step();
    @(posedge clk);
    #1;
    if (bus.O_wr_stb) obs_stb++;
    if (bus.O_frame_done) obs_fd++;
    check_all(tag);
  endtask

  initial begin
    int s0;
    int f0;
    drive(0, 3'b000, '0, '0, '0);
    model_reset();
    #2;
    check_all("reset");
    check("reset_busy", 128'(bus.O_busy), 128'(0));
    #10 rst = 1'b0;

    // Idle ignores valids.
    drive(0, 3'b111, 'h1, 'h2, 'h3);
    tick("idle_vld");
    check("idle_no_stb", 128'(bus.O_wr_stb), 128'(0));

    // First frame: all three in one cycle.
    drive(1, 3'b000, '0, '0, '0);
    tick("sof1");
    drive(0, 3'b111, 'hA, 'hB, 'hC);
    tick("first");
    check("first_stb", 128'(bus.O_wr_stb), 128'(1));
    check("first_addr", 128'(bus.O_address_out), 128'(0));
    check("first_d0", bus.O_data_out[0], 128'hA);
    check("first_d1", bus.O_data_out[1], 128'hB);
    check("first_d2", bus.O_data_out[2], 128'hC);
    check("first_ovf", 128'(bus.O_overflow), 128'(0));

    // Staggered arrival: ch0 cycle 2, ch2 cycle 5, ch1 cycle 9.
    s0 = obs_stb;
    for (int c = 1; c <= 9; c++) begin
      case (c)
        2:       drive(0, 3'b100, 'h10, '0, '0);
        5:       drive(0, 3'b001, '0, '0, 'h12);
        9:       drive(0, 3'b010, '0, 'h11, '0);
        default: drive(0, 3'b000, '0, '0, '0);
      endcase
      tick("stagger");
    end
    check("stagger_count", 128'(obs_stb - s0), 128'(1));
    check("stagger_stb", 128'(bus.O_wr_stb), 128'(1));
    check("stagger_addr", 128'(bus.O_address_out), 128'(1));
    check("stagger_d0", bus.O_data_out[0], 128'h10);
    check("stagger_d1", bus.O_data_out[1], 128'h11);
    check("stagger_d2", bus.O_data_out[2], 128'h12);

    // Overrun on ch0 keeps the first batch.
    drive(0, 3'b100, 'h1, '0, '0);
    tick("ovr_a");
    drive(0, 3'b100, 'h2, '0, '0);
    tick("ovr_b");
    check("ovr_flag", 128'(bus.O_overflow), 128'(1));
    drive(0, 3'b011, '0, 'h21, 'h22);
    tick("ovr_wr");
    check("ovr_d0", bus.O_data_out[0], 128'h1);
    check("ovr_addr", 128'(bus.O_address_out), 128'(2));
    drive(1, 3'b000, '0, '0, '0);
    tick("ovr_sof");
    check("ovr_cleared", 128'(bus.O_overflow), 128'(0));

    // Full frame, wrap, page flip, then valids ignored until sof.
    f0 = obs_fd;
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 3'b111, batch_t'(i + 'h100), batch_t'(i + 'h200), batch_t'(i + 'h300));
      tick("wrap");
      check("wrap_addr", 128'(bus.O_address_out), 128'(i));
    end
    drive(0, 3'b000, '0, '0, '0);
    tick("wrap_done");
    check("wrap_fd", 128'(bus.O_frame_done), 128'(1));
    check("wrap_page", 128'(bus.O_page), 128'(1));
    s0 = obs_stb;
    for (int i = 0; i < 3; i++) begin
      drive(0, 3'b111, 'h5, 'h6, 'h7);
      tick("wait_sof");
    end
    check("wait_no_stb", 128'(obs_stb - s0), 128'(0));
    check("wrap_fd_once", 128'(obs_fd - f0), 128'(1));
    drive(1, 3'b000, '0, '0, '0);
    tick("resof");

    // Completion coinciding with sof is suppressed; ch2 batch carries into the new frame.
    drive(0, 3'b110, 'h31, 'h32, '0);
    tick("sim_hold");
    drive(1, 3'b001, '0, '0, 'h43);
    tick("sim_sof");
    check("sim_no_stb", 128'(bus.O_wr_stb), 128'(0));
    drive(0, 3'b110, 'h51, 'h52, '0);
    tick("sim_wr");
    check("sim_addr", 128'(bus.O_address_out), 128'(0));
    check("sim_d0", bus.O_data_out[0], 128'h51);
    check("sim_d2", bus.O_data_out[2], 128'h43);

    // ch1 reloads on the write edge without overflow.
    drive(0, 3'b010, '0, 'h61, '0);
    tick("reload_a");
    drive(0, 3'b111, 'h70, 'h71, 'h72);
    tick("reload_wr");
    check("reload_d1", bus.O_data_out[1], 128'h61);
    check("reload_ovf", 128'(bus.O_overflow), 128'(0));
    drive(0, 3'b101, 'h80, '0, 'h82);
    tick("reload_wr2");
    check("reload_d1b", bus.O_data_out[1], 128'h71);
    check("reload_addr", 128'(bus.O_address_out), 128'(2));

    // Async reset between edges with the counter at 3 and a partial batch held.
    drive(0, 3'b100, 'h90, '0, '0);
    tick("partial");
    drive(0, 3'b000, '0, '0, '0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    check("async_page", 128'(bus.O_page), 128'(0));
    check("async_d0", bus.O_data_out[0], 128'h0);
    #2 rst = 1'b0;
    drive(0, 3'b111, 'h91, 'h92, 'h93);
    tick("post_rst");
    check("post_rst_no_stb", 128'(bus.O_wr_stb), 128'(0));
    drive(1, 3'b000, '0, '0, '0);
    tick("post_sof");
    drive(0, 3'b111, 'hA1, 'hA2, 'hA3);
    tick("post_wr");
    check("post_addr", 128'(bus.O_address_out), 128'(0));
    check("post_stb", 128'(bus.O_wr_stb), 128'(1));

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      logic [0:2] v;
      for (int ch = 0; ch < 3; ch++) v[ch] = ($urandom_range(0, 99) < 45);
      drive($urandom_range(0, 39) == 0, v,
            {$urandom(), $urandom(), $urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()});
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
